// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
package spi_sched_pkg;

  localparam int BYTE_W  = 8;
  localparam int DIV_MIN = 4;
  localparam int GAP_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } sched_st_t;

endpackage

// File: rtl/spi_sched_arb.sv
// NREQ-way arbiter producing a one-hot winner.
// SPI_SCHED_RR_EN defined: round-robin, search starts after the last grant.
// SPI_SCHED_RR_EN undefined: fixed priority, lowest index wins, no state.
module spi_sched_arb #(
  parameter int NREQ = 2
) (
`ifdef SPI_SCHED_RR_EN
  input  logic            clk,
  input  logic            rst,
  input  logic            upd,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] win,
  output logic            any
);

`ifdef SPI_SCHED_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;

  // Rotating search starting at the pointer; first requester found wins.
  always_comb begin
    int  k;
    logic found;
    logic take;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    take    = 1'b0;
    k       = 0;
    any     = |req;
    for (int i = 0; i < NREQ; i++) begin
      k       = (i + int'(ptr)) % NREQ;
      take    = !found && req[k];
      win[k]  = win[k] | take;
      win_idx = take ? PW'(k) : win_idx;
      found   = found | take;
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end else begin
      ptr <= ptr;
    end
  end
`else
  // Fixed priority: lowest set request bit wins.
  always_comb begin
    logic found;
    logic take;
    win   = '0;
    found = 1'b0;
    take  = 1'b0;
    any   = |req;
    for (int i = 0; i < NREQ; i++) begin
      take   = !found && req[i];
      win[i] = take;
      found  = found | take;
    end
  end
`endif

endmodule

// File: rtl/spi_xfer_sched.sv
// SPI master transfer scheduler: arbitrates NREQ requesters onto one
// mode-0 SPI bus and runs one full-duplex byte per grant.
// Optional SPI_SCHED_RR_EN selects round-robin arbitration (see spi_sched_arb).
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int NSLV  = 4,
  parameter int DIV   = 4,
  parameter int GAP   = 4,
  localparam int SLV_W = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic [NREQ-1:0]          Req_i,
  input  logic [NREQ*SLV_W-1:0]    Slv_i,
  input  logic [NREQ*BYTE_W-1:0]   TxData_i,
  output logic [NREQ-1:0]          Gnt_o,
  output logic [NREQ-1:0]          Done_o,
  output logic [BYTE_W-1:0]        RxData_o,
  output logic                     Busy_o,
  output logic                     sck_o,
  output logic                     mosi_o,
  output logic [NSLV-1:0]          ss_o,
  input  logic                     miso_i
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (DIV < DIV_MIN) begin : g_div_chk
    $error("spi_xfer_sched: DIV must be >= %0d", DIV_MIN);
  end
  if (GAP < GAP_MIN) begin : g_gap_chk
    $error("spi_xfer_sched: GAP must be >= %0d", GAP_MIN);
  end

  sched_st_t         state;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic              slv_ok;

  logic [NREQ-1:0]   win;
  logic              any_req;
  logic [SLV_W-1:0]  slv_sel;
  logic [BYTE_W-1:0] tx_sel;
  logic [NSLV-1:0]   ss_dec;
  logic              slv_in_range;

`ifdef SPI_SCHED_RR_EN
  logic grant_evt;
  assign grant_evt = (state == ST_IDLE) && any_req;
`endif

  spi_sched_arb #(.NREQ(NREQ)) u_arb (
`ifdef SPI_SCHED_RR_EN
    .clk (Clk_i),
    .rst (Rst_i),
    .upd (grant_evt),
`endif
    .req (Req_i),
    .win (win),
    .any (any_req)
  );

  // Route the winner's slave index and byte to the capture point.
  always_comb begin
    slv_sel = '0;
    tx_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      slv_sel = win[i] ? Slv_i[i*SLV_W +: SLV_W]       : slv_sel;
      tx_sel  = win[i] ? TxData_i[i*BYTE_W +: BYTE_W]  : tx_sel;
    end
  end

  // Decode slave index to one-hot SS; out-of-range indices select nobody.
  always_comb begin
    ss_dec = '0;
    for (int j = 0; j < NSLV; j++) begin
      ss_dec[j] = (int'(slv_sel) == j);
    end
    slv_in_range = (int'(slv_sel) < NSLV);
  end

  // Transfer FSM with half-period counter, bit counter and shift registers.
  // The GAP state runs GAP-1 cycles; the mandatory IDLE cycle makes up the
  // remaining SS-low cycle so the next grant lands exactly GAP cycles later.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= 4'd0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      slv_ok   <= 1'b0;
      Gnt_o    <= '0;
      Done_o   <= '0;
      RxData_o <= '0;
      Busy_o   <= 1'b0;
      sck_o    <= 1'b0;
      mosi_o   <= 1'b0;
      ss_o     <= '0;
    end else begin
      Done_o <= '0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (any_req) begin
            state   <= ST_SETUP;
            Gnt_o   <= win;
            ss_o    <= ss_dec;
            slv_ok  <= slv_in_range;
            tx_sr   <= tx_sel;
            mosi_o  <= tx_sel[BYTE_W-1];
            bit_cnt <= 4'd0;
            Busy_o  <= 1'b1;
          end else begin
            Busy_o  <= 1'b0;
          end
        end
        ST_SETUP, ST_LOW: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt     <= '0;
            state   <= ST_HIGH;
            sck_o   <= 1'b1;
            rx_sr   <= {rx_sr[BYTE_W-2:0], miso_i};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HIGH: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            sck_o <= 1'b0;
            if (bit_cnt == 4'd8) begin
              state <= ST_HOLD;
            end else begin
              state  <= ST_LOW;
              tx_sr  <= {tx_sr[BYTE_W-2:0], 1'b0};
              mosi_o <= tx_sr[BYTE_W-2];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt      <= '0;
            state    <= ST_GAP;
            RxData_o <= slv_ok ? rx_sr : 8'h00;
            Done_o   <= Gnt_o;
            Gnt_o    <= '0;
            ss_o     <= '0;
            mosi_o   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 2)) begin
            cnt    <= '0;
            state  <= ST_IDLE;
            Busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          Gnt_o  <= '0;
          ss_o   <= '0;
          sck_o  <= 1'b0;
          Busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched with a mode-0 slave model and a
// scoreboard of expected {grant, received byte} per completed transfer.
module tb_spi_xfer_sched;

  localparam int DIV = 4;
  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req;
  logic [3:0]  slv;
  logic [15:0] txd;
  logic [1:0]  gnt, done;
  logic [7:0]  rxd;
  logic        busy, sck, mosi;
  logic [3:0]  ss;
  logic        miso;

  logic [1:0]  req3;
  logic [3:0]  slv3;
  logic [15:0] txd3;
  logic [1:0]  gnt3, done3;
  logic [7:0]  rxd3;
  logic        busy3, sck3, mosi3;
  logic [2:0]  ss3;
  logic        miso3;

  spi_xfer_sched #(.NREQ(2), .NSLV(4), .DIV(DIV), .GAP(GAP)) dut (
    .Clk_i(clk), .Rst_i(rst), .Req_i(req), .Slv_i(slv), .TxData_i(txd),
    .Gnt_o(gnt), .Done_o(done), .RxData_o(rxd), .Busy_o(busy),
    .sck_o(sck), .mosi_o(mosi), .ss_o(ss), .miso_i(miso)
  );

  spi_xfer_sched #(.NREQ(2), .NSLV(3), .DIV(DIV), .GAP(GAP)) dut3 (
    .Clk_i(clk), .Rst_i(rst), .Req_i(req3), .Slv_i(slv3), .TxData_i(txd3),
    .Gnt_o(gnt3), .Done_o(done3), .RxData_o(rxd3), .Busy_o(busy3),
    .sck_o(sck3), .mosi_o(mosi3), .ss_o(ss3), .miso_i(miso3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0] exp_q[$];
  logic [7:0] got_q[$];

  logic [7:0] slave_ret = 8'h00;
  logic [7:0] sh_tx = 8'h00;
  logic [7:0] sh_rx = 8'h00;
  logic       prev_sck = 1'b0;
  logic [3:0] prev_ss = 4'd0;
  int         rise_cnt = 0;
  int         first_rise_cyc = 0;

  // Cycle counter: number of rising clock edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave model: samples MOSI on SCK rise, shifts MISO on SCK fall,
  // reloads its reply while deselected, logs each received byte on deselect.
  always @(negedge clk) begin
    if (ss != 4'd0 && prev_ss == 4'd0) rise_cnt = 0;
    if (ss == 4'd0) begin
      if (prev_ss != 4'd0) got_q.push_back(sh_rx);
      sh_tx = slave_ret;
      miso  = slave_ret[7];
    end else begin
      if (sck && !prev_sck) begin
        sh_rx = {sh_rx[6:0], mosi};
        rise_cnt++;
        if (rise_cnt == 1) first_rise_cyc = cyc;
      end
      if (!sck && prev_sck) begin
        sh_tx = {sh_tx[6:0], 1'b0};
        miso  = sh_tx[7];
      end
    end
    prev_sck = sck;
    prev_ss  = ss;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = 2'b00;
    req3 = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done !== 2'b00 || done3 !== 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; slv = 4'd0; txd = 16'd0;
    req3 = 2'b00; slv3 = 4'd0; txd3 = 16'd0; miso3 = 1'b1;
    repeat (3) tick();
    total++;
    if ({gnt, done, rxd, busy, sck, mosi, ss} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {gnt, done, rxd, busy, sck, mosi, ss});
    end
    total++;
    if ({gnt3, done3, rxd3, busy3, sck3, mosi3, ss3} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs3: got %h want 0", {gnt3, done3, rxd3, busy3, sck3, mosi3, ss3});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int t0;
    int ss_cnt;
    bit ok;
    logic [9:0] e;
    slave_ret = 8'h3C; slv = {2'd0, 2'd2}; txd = {8'h00, 8'hA5};
    tick();
    req = 2'b01;
    t0 = cyc;
    exp_q.push_back({2'b01, 8'h3C});
    tick();
    total++;
    if ({gnt, ss, mosi, busy} !== {2'b01, 4'b0100, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b ss=%b mosi=%b busy=%b want 01 0100 1 1", gnt, ss, mosi, busy);
    end
    ss_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ss === 4'b0100) ss_cnt++;
      tick();
      if (done !== 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    req = 2'b00;
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: got no done want done"); end
    total++;
    if (cyc - t0 !== 69) begin bad++; $display("FAIL single_latency: got %0d want 69", cyc - t0); end
    total++;
    if (first_rise_cyc - t0 !== 1 + DIV) begin
      bad++; $display("FAIL single_first_rise: got %0d want %0d", first_rise_cyc - t0, 1 + DIV);
    end
    total++;
    if (ss_cnt !== 17 * DIV) begin bad++; $display("FAIL single_ss_len: got %0d want %0d", ss_cnt, 17 * DIV); end
    e = exp_q.pop_front();
    total++;
    if ({done, rxd} !== e) begin bad++; $display("FAIL single_result: got %h want %h", {done, rxd}, e); end
    total++;
    if (got_q.size() == 0) begin
      bad++; $display("FAIL single_mosi: got nothing want a5");
    end else begin
      e[7:0] = got_q.pop_front();
      if (e[7:0] !== 8'hA5) begin bad++; $display("FAIL single_mosi: got %h want a5", e[7:0]); end
    end
    tick();
    total++;
    if (done !== 2'b00) begin bad++; $display("FAIL single_pulse: got %b want 00", done); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [9:0] e;
    logic [7:0] g;
    logic [7:0] want_tx;
    apply_reset();
    slave_ret = 8'h5A; slv = {2'd3, 2'd1}; txd = {8'h22, 8'h11};
    tick();
    req = 2'b11;
`ifdef SPI_SCHED_RR_EN
    exp_q.push_back({2'b01, 8'h5A}); exp_q.push_back({2'b10, 8'h5A}); exp_q.push_back({2'b01, 8'h5A});
`else
    exp_q.push_back({2'b01, 8'h5A}); exp_q.push_back({2'b01, 8'h5A}); exp_q.push_back({2'b01, 8'h5A});
`endif
    for (int k = 0; k < 3; k++) begin
      wait_done(150, ok);
      if (k == 2) req = 2'b00;
      total++;
      if (!ok) begin bad++; $display("FAIL simul_timeout%0d: got no done want done", k); end
      e = exp_q.pop_front();
      total++;
      if ({done, rxd} !== e) begin bad++; $display("FAIL simul_result%0d: got %h want %h", k, {done, rxd}, e); end
      want_tx = (e[9:8] == 2'b01) ? 8'h11 : 8'h22;
      g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
      total++;
      if (g !== want_tx) begin bad++; $display("FAIL simul_mosi%0d: got %h want %h", k, g, want_tx); end
    end
  endtask

  task automatic test_req_drop();
    bit ok;
    int extra;
    logic [9:0] e;
    logic [7:0] g;
    slave_ret = 8'hC3; slv = {2'd0, 2'd1}; txd = {8'h00, 8'h0F};
    repeat (GAP + 2) tick();
    rise_cnt = 0;
    req = 2'b01;
    exp_q.push_back({2'b01, 8'hC3});
    for (int i = 0; i < 100 && rise_cnt < 4; i++) tick();
    req = 2'b00; txd = 16'hFFFF; slv = {2'd0, 2'd2};
    wait_done(150, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_timeout: got no done want done"); end
    e = exp_q.pop_front();
    total++;
    if ({done, rxd} !== e) begin bad++; $display("FAIL drop_result: got %h want %h", {done, rxd}, e); end
    g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
    total++;
    if (g !== 8'h0F) begin bad++; $display("FAIL drop_mosi: got %h want 0f", g); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 2'b00) extra++;
    end
    total++;
    if ({extra, gnt, busy} !== {32'd0, 2'b00, 1'b0}) begin
      bad++; $display("FAIL drop_after: got extra=%0d gnt=%b busy=%b want 0 00 0", extra, gnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    slave_ret = 8'h99; slv = {2'd0, 2'd0}; txd = {8'h00, 8'h96};
    tick();
    rise_cnt = 0;
    req = 2'b01;
    for (int i = 0; i < 100 && rise_cnt < 5; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({ss, sck, busy, done, rxd, gnt} !== 17'd0) begin
      bad++;
      $display("FAIL rstmid_outputs: got ss=%b sck=%b busy=%b done=%b rxd=%h gnt=%b want all 0",
               ss, sck, busy, done, rxd, gnt);
    end
    tick();
    rst = 1'b0; req = 2'b00;
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done !== 2'b00) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL rstmid_nodone: got %0d want 0", extra); end
    got_q.delete();
  endtask

  task automatic test_out_of_range();
    int t0;
    int ss_nz;
    bit ok;
    logic [9:0] e;
    slv3 = {2'd0, 2'd3}; txd3 = {8'h00, 8'h5F};
    req3 = 2'b01;
    t0 = cyc;
    exp_q.push_back({2'b01, 8'h00});
    ss_nz = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ss3 !== 3'b000) ss_nz++;
      if (done3 !== 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    req3 = 2'b00;
    total++;
    if (!ok) begin bad++; $display("FAIL oor_timeout: got no done want done"); end
    total++;
    if (ss_nz !== 0) begin bad++; $display("FAIL oor_ss: got %0d selected cycles want 0", ss_nz); end
    total++;
    if (cyc - t0 !== 69) begin bad++; $display("FAIL oor_latency: got %0d want 69", cyc - t0); end
    e = exp_q.pop_front();
    total++;
    if ({done3, rxd3} !== e) begin bad++; $display("FAIL oor_result: got %h want %h", {done3, rxd3}, e); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gap_cnt;
    logic [9:0] e;
    logic [7:0] g;
    logic [7:0] want2;
    apply_reset();
    slave_ret = 8'hE7; slv = {2'd2, 2'd0}; txd = {8'h7E, 8'h81};
    tick();
    req = 2'b11;
    exp_q.push_back({2'b01, 8'hE7});
`ifdef SPI_SCHED_RR_EN
    exp_q.push_back({2'b10, 8'hE7});
    want2 = 8'h7E;
`else
    exp_q.push_back({2'b01, 8'hE7});
    want2 = 8'h81;
`endif
    wait_done(150, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout1: got no done want done"); end
    e = exp_q.pop_front();
    total++;
    if ({done, rxd} !== e) begin bad++; $display("FAIL b2b_result1: got %h want %h", {done, rxd}, e); end
    g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
    total++;
    if (g !== 8'h81) begin bad++; $display("FAIL b2b_mosi1: got %h want 81", g); end
    gap_cnt = 0;
    for (int i = 0; i < 20 && ss === 4'd0; i++) begin
      gap_cnt++;
      tick();
    end
    total++;
    if (gap_cnt !== GAP) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gap_cnt, GAP); end
    total++;
    if (gnt !== exp_q[0][9:8]) begin bad++; $display("FAIL b2b_grant2: got %b want %b", gnt, exp_q[0][9:8]); end
    wait_done(150, ok);
    req = 2'b00;
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout2: got no done want done"); end
    e = exp_q.pop_front();
    total++;
    if ({done, rxd} !== e) begin bad++; $display("FAIL b2b_result2: got %h want %h", {done, rxd}, e); end
    g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
    total++;
    if (g !== want2) begin bad++; $display("FAIL b2b_mosi2: got %h want %h", g, want2); end
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_req_drop();
    test_reset_mid();
    test_out_of_range();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

SPI master-side transfer scheduler that shares one SPI bus between `NREQ` on-chip requesters and sequences complete one-byte, full-duplex transfers to any of `NSLV` slaves. It arbitrates requests, drives SCK/MOSI/SS, samples MISO, and returns the received byte to the granted requester. The SCK timing and inter-transfer gap are sized for the codebase's oversampled slave, which double-synchronises SCK/SS/MOSI and reloads its transmit byte while deselected.

## Interface
- `NREQ`, 2: number of requesters (≥1).
- `NSLV`, 4: number of slaves / SS lines (≥1).
- `DIV`, 4: clocks per SCK half-period. Must be ≥4; elaboration error otherwise.
- `GAP`, 4: clocks with all SS low between transfers (≥4).

Ports:
- `Clk_i  in  1`: single clock.
- `Rst_i  in  1`: reset, synchronous, active-high.
- `Req_i  in  NREQ`: per-requester transfer request (level).
- `Slv_i  in  NREQ*$clog2(NSLV)`: packed target slave index per requester.
- `TxData_i  in  NREQ*8`: packed byte to send per requester.
- `Gnt_o  out  NREQ`: one-hot grant, held for the whole transfer.
- `Done_o  out  NREQ`: one-cycle completion pulse to the granted requester.
- `RxData_o  out  8`: last received byte.
- `Busy_o  out  1`: transfer or gap in progress.
- `sck_o  out  1`: SPI clock, mode 0, idle low.
- `mosi_o  out  1`: serial data out, MSB first.
- `ss_o  out  NSLV`: one-hot slave select, active-high.
- `miso_i  in  1`: serial data in.

## Operation
- **Reset:** all outputs are 0, state is IDLE, and the arbitration pointer is 0. A reset asserted mid-transfer forces IDLE on the next clock, drops SS and SCK, and produces no `Done_o`.
- **States:**
  - **IDLE → SETUP** when any `Req_i` bit is set.
  - **SETUP** (DIV cycles, SCK low) → **HIGH**.
  - **HIGH** (DIV cycles, SCK=1) → **LOW** if fewer than 8 bits are done, else → **HOLD**.
  - **LOW** (DIV cycles, SCK=0) → **HIGH**.
  - **HOLD** (DIV cycles, SCK=0, SS still asserted) → **GAP**.
  - **GAP** (GAP cycles, SS=0) → **IDLE**.
- **On IDLE→SETUP:**
  - Grant the arbitration winner.
  - Capture its `Slv_i` and `TxData_i`.
  - Assert `ss_o[slv]`.
  - Drive `mosi_o` = tx[7].
- **Bit handling:**
  - MISO is sampled into the RX shift register on each transition into HIGH (the rising SCK edge).
  - MOSI advances to the next bit on each HIGH→LOW transition (the falling edge).
- **On HOLD→GAP:**
  - `RxData_o` ← RX shift register.
  - `Done_o[granted]` pulses for exactly one cycle.
  - `Gnt_o` and `ss_o` clear.
- **Mid-transfer input changes:** once granted, changes to `Req_i`, `Slv_i` or `TxData_i` are ignored. The transfer always completes and `Done_o` still pulses.
- **Requester handshake:** a requester drops `Req_i` on `Done_o`. If it keeps `Req_i` high, it re-arbitrates in IDLE.
- **Out-of-range slave:** if `Slv_i` ≥ NSLV, the full sequence runs with `ss_o` all 0 and `RxData_o` = 8'h00.
- **Busy_o:** 1 in every state except IDLE.

## Timing
- A request seen at cycle t in IDLE gives grant, SS and MOSI valid at t+1.
- The first SCK rise is at t+1+DIV.
- The transfer lasts 17·DIV cycles from SETUP entry to GAP entry. `Done_o` pulses at t+1+17·DIV, which is t+69 for DIV=4.
- The earliest next grant is at t+1+17·DIV+GAP.
- MISO is sampled on the same clock edge that sets SCK=1, so the slave's shift (≥2 cycles after the rise) never corrupts the sample.

## Configuration
- `SPI_SCHED_RR_EN` defined: round-robin arbitration. Search starts at (last granted + 1) mod NREQ; the pointer updates on each grant.
- `SPI_SCHED_RR_EN` undefined: fixed priority, lowest index wins, and no pointer register is present.

## Structure
- Package `spi_sched_pkg`: state enum `sched_st_t` (IDLE, SETUP, HIGH, LOW, HOLD, GAP), `BYTE_W`=8, and the minimum `DIV`/`GAP` constants.
- Sub-module `spi_sched_arb`: NREQ-way arbiter producing a one-hot winner. It contains the `SPI_SCHED_RR_EN` logic.
- The rest (FSM, half-period counter, bit counter, TX/RX shift registers) lives in `spi_xfer_sched`.

## Test plan
1. **Single transfer.** Req_i=01, Slv_i[0]=2, TxData_i[0]=8'hA5, slave model returns 8'h3C → `ss_o`=0100 for 17·DIV cycles, MOSI bits 1,0,1,0,0,1,0,1 on the rising edges, `Done_o`=01 at t+69, `RxData_o`=8'h3C.
2. **Simultaneous requests.** Req_i=11 held through completions → RR: grants 01, 10, 01; fixed priority: grants 01, 01, 01.
3. **Request dropped mid-transfer.** Req_i falls during bit 4 → transfer completes and `Done_o` still pulses once.
4. **Reset mid-transfer.** Rst_i=1 in the bit-5 HIGH phase → next cycle `ss_o`=0, `sck_o`=0, `Busy_o`=0, no `Done_o`, `RxData_o`=0.
5. **Out-of-range slave.** NSLV=3, Slv_i=3 → `ss_o`=000 throughout, `Done_o` pulses, `RxData_o`=8'h00.
6. **Back-to-back gap.** Req_i held high → `ss_o` all 0 for exactly GAP cycles between transfers, and the slave model receives both bytes intact.
